hcsr_range_ctrl: RTL and testbench

HCSR_RANGE_CTRL -- requirements
Module: hcsr_range_ctrl

---
 rtl/hcsr_range_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hcsr_range_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hcsr_range_ctrl.sv
// Periodic ranging controller: fires a measure pulse, waits for the echo width, converts it to cm
// by repeated subtraction and publishes it. Optional macro HCSR_RANGE_AVG_EN adds a 4-entry mean.
module hcsr_range_ctrl #(
    parameter logic [16:0] PERIOD_US  = 17'd60000,
    parameter logic [16:0] TIMEOUT_US = 17'd30000,
    parameter logic [9:0]  MAX_CM     = 10'd400
) (
    input  logic        clk_1MHz,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        sensor_ready,
    input  logic [21:0] distance_raw,
    output logic        measure,
    output logic        sensor_rst,
    output logic [9:0]  dist_cm,
    output logic        dist_valid,
    output logic        out_of_range,
    output logic        timeout,
    output logic        busy
);
    localparam logic [21:0] US_PER_CM = 22'd58;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT_DONE,
        DIVIDE,
        PUBLISH,
        HOLDOFF
    } state_t;

    state_t      state_q;
    logic [16:0] elapsed_q;
    logic        seen_busy_q;
    logic        armed_q;
    logic [21:0] rem_q;
    logic [9:0]  quo_q;
    logic        measure_q;
    logic        sensor_rst_q;
    logic        dist_valid_q;
    logic        oor_q;
    logic        timeout_q;
    logic        busy_q;
    logic [9:0]  dist_cm_q;
    logic [9:0]  result_d;
    logic        rem_ge;

    assign rem_ge = (rem_q >= US_PER_CM);

`ifdef HCSR_RANGE_AVG_EN
    logic [3:0][9:0] win_q;
    logic            win_init_q;
    logic [11:0]     win_sum;

    // Mean of the window as it will look once the current quotient is shifted in.
    always_comb begin
        if (win_init_q) begin
            win_sum = {2'b00, win_q[3]} + {2'b00, win_q[2]} + {2'b00, win_q[1]} + {2'b00, quo_q};
        end else begin
            win_sum = {quo_q, 2'b00};
        end
        result_d = rem_ge ? MAX_CM : win_sum[11:2];
    end

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            win_q      <= '0;
            win_init_q <= 1'b0;
        end else if (state_q == PUBLISH && !rem_ge) begin
            win_q      <= win_init_q ? {quo_q, win_q[3:1]} : {4{quo_q}};
            win_init_q <= 1'b1;
        end
    end
`else
    assign result_d = quo_q;
`endif

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            elapsed_q    <= '0;
            seen_busy_q  <= 1'b0;
            armed_q      <= 1'b0;
            rem_q        <= '0;
            quo_q        <= '0;
            measure_q    <= 1'b0;
            sensor_rst_q <= 1'b0;
            dist_valid_q <= 1'b0;
            oor_q        <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            dist_cm_q    <= '0;
        end else begin
            measure_q    <= 1'b0;
            sensor_rst_q <= 1'b0;
            dist_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            // Holds off the first measure by one extra edge after reset release.
            armed_q      <= 1'b1;
            if (state_q != IDLE && state_q != FIRE && !(&elapsed_q)) begin
                elapsed_q <= elapsed_q + 17'd1;
            end
            case (state_q)
                IDLE: begin
                    if (armed_q && enable && sensor_ready) begin
                        state_q   <= FIRE;
                        measure_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                FIRE: begin
                    elapsed_q   <= '0;
                    seen_busy_q <= 1'b0;
                    state_q     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (elapsed_q == TIMEOUT_US) begin
                        timeout_q    <= 1'b1;
                        sensor_rst_q <= 1'b1;
                        state_q      <= HOLDOFF;
                    end else if (sensor_ready && seen_busy_q) begin
                        rem_q   <= distance_raw;
                        quo_q   <= '0;
                        state_q <= DIVIDE;
                    end else if (!sensor_ready) begin
                        seen_busy_q <= 1'b1;
                    end
                end
                DIVIDE: begin
                    if (rem_ge && quo_q < MAX_CM) begin
                        rem_q <= rem_q - US_PER_CM;
                        quo_q <= quo_q + 10'd1;
                    end else begin
                        state_q <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    dist_cm_q    <= result_d;
                    oor_q        <= rem_ge;
                    dist_valid_q <= 1'b1;
                    state_q      <= HOLDOFF;
                end
                HOLDOFF: begin
                    if (elapsed_q >= PERIOD_US) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign measure      = measure_q;
    assign sensor_rst   = sensor_rst_q;
    assign dist_cm      = dist_cm_q;
    assign dist_valid   = dist_valid_q;
    assign out_of_range = oor_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_hcsr_range_ctrl.sv
// Scoreboard bench for hcsr_range_ctrl: a sensor model drives echoes, a reference model predicts
// each published result or timeout, and a monitor checks every output pulse against the queue.
module tb_hcsr_range_ctrl;
    localparam int PERIOD = 700;
    localparam int TOUT   = 300;
    localparam int MAXCM  = 400;

    logic        clk = 1'b0;
    logic        rstN;
    logic        enable;
    logic        sensorReady;
    logic [21:0] distanceRaw;
    logic        measure;
    logic        sensorRst;
    logic [9:0]  distCm;
    logic        distValid;
    logic        outOfRange;
    logic        timeoutO;
    logic        busy;

    int compared    = 0;
    int mismatched  = 0;
    int cycle       = 0;
    int lastMeasure = -1;
    int lastCm      = 0;
    bit lastOor     = 1'b0;
    int win[$];

    typedef struct {
        bit isTimeout;
        int cm;
        bit oor;
        int due;
    } exp_t;
    exp_t sb[$];

    hcsr_range_ctrl #(
        .PERIOD_US (17'd700),
        .TIMEOUT_US(17'd300),
        .MAX_CM    (10'd400)
    ) dut (
        .clk_1MHz    (clk),
        .rst_n       (rstN),
        .enable      (enable),
        .sensor_ready(sensorReady),
        .distance_raw(distanceRaw),
        .measure     (measure),
        .sensor_rst  (sensorRst),
        .dist_cm     (distCm),
        .dist_valid  (distValid),
        .out_of_range(outOfRange),
        .timeout     (timeoutO),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference: floor(raw/58) saturated at MAX_CM; the divider spends one cycle per unit of quotient.
    task automatic modelResult(input int raw, output int cm, output bit oor, output int steps);
        int q;
        q     = raw / 58;
        oor   = (q > MAXCM);
        steps = oor ? MAXCM : q;
        cm    = steps;
`ifdef HCSR_RANGE_AVG_EN
        if (!oor) begin
            if (win.size() == 0) begin
                repeat (4) win.push_back(q);
            end else begin
                void'(win.pop_front());
                win.push_back(q);
            end
            cm = (win[0] + win[1] + win[2] + win[3]) / 4;
        end
`endif
    endtask

    task automatic waitMeasure(output int m, output bit ok);
        ok = 1'b0;
        m  = 0;
        for (int i = 0; i < 2 * PERIOD + 100; i++) begin
            @(negedge clk);
            if (measure) begin
                ok = 1'b1;
                m  = cycle;
                break;
            end
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL measure wait: got no measure pulse, required one within %0d cycles", 2 * PERIOD + 100);
        end else begin
            checkOutput("busy in FIRE", busy, 1);
        end
    endtask

    task automatic applyStimulus(input int raw, input int lowCycles, input bit doTimeout,
                                 input bit checkSpacing, input bit dropEnable);
        int m, cm, capture, steps;
        bit ok, oor;
        waitMeasure(m, ok);
        if (!ok) return;
        // HOLDOFF always binds here, so measures land exactly PERIOD+3 cycles apart.
        if (checkSpacing && lastMeasure >= 0) checkOutput("measure spacing", m - lastMeasure, PERIOD + 3);
        lastMeasure = m;
        if (dropEnable) enable = 1'b0;
        sensorReady = 1'b0;
        distanceRaw = 22'($urandom);
        if (doTimeout) begin
            sb.push_back('{1'b1, lastCm, lastOor, m + TOUT + 2});
            repeat (TOUT + 2) @(negedge clk);
            sensorReady = 1'b1;
        end else begin
            repeat (lowCycles) @(negedge clk);
            distanceRaw = 22'(raw);
            sensorReady = 1'b1;
            capture     = cycle + 1;
            modelResult(raw, cm, oor, steps);
            sb.push_back('{1'b0, cm, oor, capture + steps + 2});
            lastCm  = cm;
            lastOor = oor;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rstN === 1'b1) begin
            if (distValid || timeoutO) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected pulse: got dist_valid=%0b timeout=%0b, required none (cycle %0d)",
                             distValid, timeoutO, cycle);
                end else begin
                    e = sb.pop_front();
                    checkOutput("timeout", timeoutO, e.isTimeout);
                    checkOutput("dist_valid", distValid, !e.isTimeout);
                    checkOutput("dist_cm", distCm, e.cm);
                    checkOutput("out_of_range", outOfRange, e.oor);
                    checkOutput("pulse cycle", cycle, e.due);
                    checkOutput("sensor_rst", sensorRst, e.isTimeout);
                    checkOutput("busy at pulse", busy, 1);
                end
            end
            if (measure && sensorRst) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL measure/sensor_rst overlap: got both high, required never together (cycle %0d)", cycle);
            end
        end
    end

    initial begin
        int  rel;
        bit  sawMeasure;
        rstN        = 1'b1;
        enable      = 1'b0;
        sensorReady = 1'b1;
        distanceRaw = '0;
        #1 rstN = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset outputs", {measure, sensorRst, distValid, outOfRange, timeoutO, busy, distCm}, 0);
        enable = 1'b1;
        rstN   = 1'b1;
        rel    = cycle;

        applyStimulus(580, 4, 0, 1, 0);
        checkOutput("first measure not before second edge", (lastMeasure - rel) >= 2, 1);
        applyStimulus(1160, 20, 0, 1, 0);
        applyStimulus(1740, 2, 0, 1, 0);
        applyStimulus(2320, 77, 0, 1, 0);
        applyStimulus(57, 3, 0, 1, 0);
        applyStimulus(58, 9, 0, 1, 0);
        applyStimulus(0, 2, 0, 1, 0);
        applyStimulus(30000, 12, 0, 1, 0);
        applyStimulus(23200, 5, 0, 1, 0);
        applyStimulus(23257, 6, 0, 1, 0);
        applyStimulus(23258, 7, 0, 1, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(1160, 40, 0, 1, 0);

        // Dropping enable mid-measurement must still let the result publish.
        applyStimulus(4000, 10, 0, 1, 1);
        sawMeasure = 1'b0;
        for (int i = 0; i < PERIOD + 50; i++) begin
            @(negedge clk);
            if (measure) sawMeasure = 1'b1;
        end
        checkOutput("no measure while disabled", sawMeasure, 0);
        checkOutput("busy low in idle", busy, 0);
        enable = 1'b1;
        applyStimulus(3000, 15, 0, 0, 0);

        for (int n = 0; n < 16; n++) begin
            int sel, raw;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       raw = $urandom_range(0, 600);
                1:       raw = $urandom_range(0, 25000);
                2:       raw = $urandom_range(23100, 23400);
                default: raw = int'($urandom & 32'h003F_FFFF);
            endcase
            applyStimulus(raw, $urandom_range(2, 150), ($urandom_range(0, 7) == 0), 1, 0);
        end

        applyStimulus(1160, 8, 0, 1, 0);
        applyStimulus(20000, 5, 0, 1, 0);
        repeat (100) @(negedge clk);
        #3 rstN = 1'b0;
        #1 checkOutput("async reset mid-divide", {measure, sensorRst, distValid, outOfRange, timeoutO, busy, distCm}, 0);
        sb.delete();
        win.delete();
        lastCm      = 0;
        lastOor     = 1'b0;
        lastMeasure = -1;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        rel  = cycle;
        applyStimulus(1740, 30, 0, 1, 0);
        checkOutput("measure after mid-divide reset", (lastMeasure - rel) >= 2, 1);
        applyStimulus(580, 11, 0, 1, 0);

        for (int i = 0; i < 1000 && sb.size() > 0; i++) @(negedge clk);
        checkOutput("scoreboard drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
